// File: rtl/uart_cmd_pkg.sv
// Shared definitions for the UART command link schedulers.
//   DATA_W  : default command/response frame width
//   state_e : scheduler FSM states
//   clog2   : ceil(log2(value)), 0 for value <= 1, usable in constant expressions
package uart_cmd_pkg;

    localparam int unsigned DATA_W = 128;

    typedef enum logic [2:0] {
        StIdle,
        StArb,
        StSend,
        StWaitStart,
        StWaitDone,
        StWaitRsp,
        StFinish
    } state_e;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < value) r = r + 1;
        return r;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
//   req   : request vector
//   ptr   : index with highest priority this round
//   gnt   : one-hot grant (zero when nothing is requested)
//   idx   : index of the granted requester
//   found : any request present
module rr_arbiter
    import uart_cmd_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IDX_W   = clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   idx,
    output logic               found
);

    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        // Scan from farthest to nearest so the first set request at/after ptr is kept last.
        for (int off = int'(NUM_REQ) - 1; off >= 0; off--) begin
            if (req[(int'(ptr) + off) % int'(NUM_REQ)]) begin
                idx   = IDX_W'((int'(ptr) + off) % int'(NUM_REQ));
                found = 1'b1;
            end
        end
        if (found) gnt = {{(NUM_REQ-1){1'b0}}, 1'b1} << idx;
    end

endmodule

// File: rtl/uart_cmd_sched.sv
// Round-robin scheduler sharing one UART command link between NUM_REQ requesters.
// Sends one frame at a time, optionally waits for the response with timeout/retry,
// and reports ack/err/response to the granted requester.
//   clk, rst      : clock, asynchronous active-high reset
//   req           : level requests, held until ack or err
//   req_data      : per-requester frames, requester i at [i*DATA_W +: DATA_W]
//   req_need_rsp  : requester expects a response frame
//   ack, err      : one-cycle completion pulses for the granted requester
//   rsp_data      : last received frame, held
//   rsp_vld       : one-cycle pulse to the owner of rsp_data
//   unsol_vld     : one-cycle pulse for a frame nobody was waiting for
//   busy          : scheduler not idle
//   send_en       : one-cycle start pulse to the transmit framer
//   send_data     : frame being transmitted
//   send_vld      : transmitter busy
//   rx_frame      : received frame, valid with rx_vld pulse
module uart_cmd_sched
    import uart_cmd_pkg::*;
#(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned DATA_W    = uart_cmd_pkg::DATA_W,
    parameter int unsigned START_TO  = 64,
    parameter int unsigned RSP_TO    = 20000,
    parameter int unsigned MAX_RETRY = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    input  logic [NUM_REQ-1:0]        req_need_rsp,
    output logic [NUM_REQ-1:0]        ack,
    output logic [NUM_REQ-1:0]        err,
    output logic [DATA_W-1:0]         rsp_data,
    output logic [NUM_REQ-1:0]        rsp_vld,
    output logic                      unsol_vld,
    output logic                      busy,
    output logic                      send_en,
    output logic [DATA_W-1:0]         send_data,
    input  logic                      send_vld,
    input  logic [DATA_W-1:0]         rx_frame,
    input  logic                      rx_vld
);

    localparam int unsigned IDX_W = clog2(NUM_REQ);
    localparam int unsigned TMR_W = clog2((START_TO > RSP_TO) ? START_TO : RSP_TO) + 1;
    localparam int unsigned RET_W = clog2(MAX_RETRY + 1) + 1;
    localparam logic [NUM_REQ-1:0] ONE = {{(NUM_REQ-1){1'b0}}, 1'b1};

    state_e             state;
    logic [IDX_W-1:0]   gnt_id;
    logic [IDX_W-1:0]   rr_ptr;
    logic               need_rsp;
    logic               got_rsp;
    logic               fin_ok;
    logic [RET_W-1:0]   retry_cnt;
    logic [TMR_W-1:0]   timer;

    logic [NUM_REQ-1:0] arb_gnt;
    logic [IDX_W-1:0]   arb_idx;
    logic               arb_found;
    logic               rx_accept;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_arb (
        .req   (req),
        .ptr   (rr_ptr),
        .gnt   (arb_gnt),
        .idx   (arb_idx),
        .found (arb_found)
    );

    // A frame is the response only while waiting for it; one early frame is
    // accepted while the command is still being transmitted.
    assign rx_accept = rx_vld && ((state == StWaitRsp) ||
                                  (state == StWaitDone && need_rsp && !got_rsp));
    assign busy      = (state != StIdle);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= StIdle;
            gnt_id    <= '0;
            rr_ptr    <= '0;
            need_rsp  <= 1'b0;
            got_rsp   <= 1'b0;
            fin_ok    <= 1'b0;
            retry_cnt <= '0;
            timer     <= '0;
            ack       <= '0;
            err       <= '0;
            rsp_data  <= '0;
            rsp_vld   <= '0;
            unsol_vld <= 1'b0;
            send_en   <= 1'b0;
            send_data <= '0;
        end else begin
            ack       <= '0;
            err       <= '0;
            rsp_vld   <= '0;
            unsol_vld <= 1'b0;
            send_en   <= 1'b0;

            // Saturating; each waiting state clears it on entry.
            if (timer != '1) timer <= timer + TMR_W'(1);

            if (rx_vld && !rx_accept) begin
                rsp_data  <= rx_frame;
                unsol_vld <= 1'b1;
            end

            case (state)
                StIdle: begin
                    if (req != '0 && !send_vld) state <= StArb;
                end
                StArb: begin
                    if (arb_found) begin
                        gnt_id    <= arb_idx;
                        send_data <= req_data[arb_idx*DATA_W +: DATA_W];
                        need_rsp  <= |(req_need_rsp & arb_gnt);
                        retry_cnt <= '0;
                        got_rsp   <= 1'b0;
                        send_en   <= 1'b1;
                        state     <= StSend;
                    end else begin
                        state <= StIdle;
                    end
                end
                StSend: begin
                    timer <= '0;
                    state <= StWaitStart;
                end
                StWaitStart: begin
                    if (send_vld) begin
                        state <= StWaitDone;
                    end else if (timer == TMR_W'(START_TO)) begin
                        fin_ok <= 1'b0;
                        state  <= StFinish;
                    end
                end
                StWaitDone: begin
                    if (rx_accept) begin
                        rsp_data <= rx_frame;
                        rsp_vld  <= ONE << gnt_id;
                        got_rsp  <= 1'b1;
                    end
                    if (!send_vld) begin
                        if (!need_rsp || got_rsp || rx_accept) begin
                            fin_ok <= 1'b1;
                            state  <= StFinish;
                        end else begin
                            timer <= '0;
                            state <= StWaitRsp;
                        end
                    end
                end
                StWaitRsp: begin
                    // A response arriving on the timeout cycle still wins.
                    if (rx_vld) begin
                        rsp_data <= rx_frame;
                        rsp_vld  <= ONE << gnt_id;
                        fin_ok   <= 1'b1;
                        state    <= StFinish;
                    end else if (timer == TMR_W'(RSP_TO)) begin
                        if (retry_cnt < RET_W'(MAX_RETRY)) begin
                            retry_cnt <= retry_cnt + RET_W'(1);
                            send_en   <= 1'b1;
                            state     <= StSend;
                        end else begin
                            fin_ok <= 1'b0;
                            state  <= StFinish;
                        end
                    end
                end
                StFinish: begin
                    if (fin_ok) ack <= ONE << gnt_id;
                    else        err <= ONE << gnt_id;
                    rr_ptr <= (gnt_id == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_id + IDX_W'(1);
                    state  <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_cmd_sched.sv
// Directed bench for uart_cmd_sched: table of single transactions plus
// hand-written sequences for round robin, retry, start timeout, unsolicited
// frames and mid-transaction reset. A small UART model answers send_en.
module tb_uart_cmd_sched;

    localparam int unsigned NR  = 4;
    localparam int unsigned DW  = 128;
    localparam int unsigned STO = 16;
    localparam int unsigned RTO = 600;
    localparam int unsigned MR  = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [NR-1:0]     req;
    logic [NR*DW-1:0]  req_data;
    logic [NR-1:0]     req_need_rsp;
    logic [NR-1:0]     ack;
    logic [NR-1:0]     err;
    logic [DW-1:0]     rsp_data;
    logic [NR-1:0]     rsp_vld;
    logic              unsol_vld;
    logic              busy;
    logic              send_en;
    logic [DW-1:0]     send_data;
    logic              send_vld;
    logic [DW-1:0]     rx_frame;
    logic              rx_vld;

    uart_cmd_sched #(
        .NUM_REQ   (NR),
        .DATA_W    (DW),
        .START_TO  (STO),
        .RSP_TO    (RTO),
        .MAX_RETRY (MR)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req          (req),
        .req_data     (req_data),
        .req_need_rsp (req_need_rsp),
        .ack          (ack),
        .err          (err),
        .rsp_data     (rsp_data),
        .rsp_vld      (rsp_vld),
        .unsol_vld    (unsol_vld),
        .busy         (busy),
        .send_en      (send_en),
        .send_data    (send_data),
        .send_vld     (send_vld),
        .rx_frame     (rx_frame),
        .rx_vld       (rx_vld)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    int viol = 0;
    int tot_ack = 0;
    int tot_err = 0;
    int se_cyc[8];

    // UART transmitter model: busy 3 cycles after send_en, for tx_len cycles.
    logic model_en = 1'b1;
    int   tx_len   = 5;
    int   fall_cyc = 0;
    initial begin
        send_vld = 1'b0;
        forever begin
            @(negedge clk);
            if (send_en && model_en) begin
                repeat (3) @(negedge clk);
                send_vld = 1'b1;
                repeat (tx_len) @(negedge clk);
                send_vld = 1'b0;
                fall_cyc = cyc;
            end
        end
    end

    // Pulse sanity and completion totals.
    always @(negedge clk) begin
        if (!rst) begin
            if ((ack & err) != '0 || $countones(ack) > 1 || $countones(err) > 1 ||
                $countones(rsp_vld) > 1) viol++;
            if (|ack) tot_ack++;
            if (|err) tot_err++;
        end
    end

    function automatic logic [DW-1:0] frame(input int i);
        return {32'h1234_5678, 32'hC0DE_0000 + i, 64'h0123_4567_89AB_CDE0 + 64'(i)};
    endfunction

    function automatic logic [NR-1:0] oh(input int i);
        logic [NR-1:0] one;
        one = 1;
        return one << i;
    endfunction

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_lvl(input string name, input logic lvl);
        bit seen;
        seen = 0;
        for (int i = 0; i < 300 && !seen; i++) begin
            tick();
            if (send_vld == lvl) seen = 1;
        end
        chk(name, seen, 1'b1);
    endtask

    task automatic wait_ack(input int limit, output logic [NR-1:0] a, output logic [NR-1:0] e,
                            output int at, output int ns);
        a = '0;
        e = '0;
        at = -1;
        ns = 0;
        for (int i = 0; i < limit; i++) begin
            tick();
            if (send_en) begin
                if (ns < 8) se_cyc[ns] = cyc;
                ns++;
            end
            if (|ack || |err) begin
                a  = ack;
                e  = err;
                at = cyc;
                break;
            end
        end
        checks++;
        if (at < 0) begin
            errors++;
            $display("FAIL ack/err wait: none within %0d cycles, required one", limit);
        end
    endtask

    task automatic pulse_rx(input logic [DW-1:0] f);
        rx_frame = f;
        rx_vld   = 1'b1;
        tick();
        rx_vld   = 1'b0;
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    // mode 0: no response, 1: response dly cycles after send_vld falls,
    // 2: response while the command is still being transmitted.
    typedef struct {
        logic [NR-1:0] req;
        logic [NR-1:0] need;
        int            mode;
        int            dly;
        int            txl;
        logic [DW-1:0] rsp;
        int            exp_idx;
    } vec_t;

    task automatic run_vec(input vec_t v, input int k);
        int t0, rx_c, at, ns;
        bit got;
        logic [NR-1:0] a, e;
        tx_len       = v.txl;
        req_need_rsp = v.need;
        t0           = cyc;
        req          = v.req;
        got          = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            tick();
            if (send_en) got = 1;
        end
        chk($sformatf("v%0d send_en seen", k), got, 1'b1);
        chk($sformatf("v%0d send_en latency", k), cyc - t0, 2);
        chk($sformatf("v%0d send_data", k), send_data, frame(v.exp_idx));
        rx_c = -1;
        if (v.mode != 0) begin
            wait_lvl($sformatf("v%0d send_vld rise", k), 1'b1);
            if (v.mode == 1) wait_lvl($sformatf("v%0d send_vld fall", k), 1'b0);
            repeat (v.dly) tick();
            rx_c = cyc;
            pulse_rx(v.rsp);
            chk($sformatf("v%0d rsp_vld", k), rsp_vld, oh(v.exp_idx));
            chk($sformatf("v%0d rsp_data", k), rsp_data, v.rsp);
        end
        wait_ack(RTO + 300, a, e, at, ns);
        req = '0;
        chk($sformatf("v%0d ack", k), a, oh(v.exp_idx));
        chk($sformatf("v%0d err", k), e, '0);
        if (v.mode == 1) chk($sformatf("v%0d ack timing", k), at - rx_c, 2);
        else             chk($sformatf("v%0d ack timing", k), at - fall_cyc, 2);
        tick();
        tick();
    endtask

    vec_t vecs[6];
    int   rr_exp[5] = '{0, 1, 2, 3, 0};

    initial begin
        logic [NR-1:0] a, e;
        int at, ns, a0, e0;

        rst          = 1'b1;
        req          = '0;
        req_need_rsp = '0;
        rx_frame     = '0;
        rx_vld       = 1'b0;
        for (int i = 0; i < int'(NR); i++) req_data[i*DW +: DW] = frame(i);

        vecs[0] = '{req: 4'b0001, need: 4'b0000, mode: 0, dly: 0,   txl: 100, rsp: '0,
                    exp_idx: 0};
        vecs[1] = '{req: 4'b0100, need: 4'b0100, mode: 1, dly: 500, txl: 5,
                    rsp: 128'hC0FFEE, exp_idx: 2};
        vecs[2] = '{req: 4'b0110, need: 4'b0000, mode: 0, dly: 0,   txl: 5, rsp: '0,
                    exp_idx: 1};
        vecs[3] = '{req: 4'b1001, need: 4'b1000, mode: 1, dly: 0,   txl: 5,
                    rsp: 128'hABCD_0003, exp_idx: 3};
        vecs[4] = '{req: 4'b1001, need: 4'b0001, mode: 2, dly: 2,   txl: 20,
                    rsp: 128'hBEEF_0004, exp_idx: 0};
        vecs[5] = '{req: 4'b1100, need: 4'b0000, mode: 0, dly: 0,   txl: 5, rsp: '0,
                    exp_idx: 2};

        // Reset state.
        tick();
        chk("reset ack", ack, '0);
        chk("reset err", err, '0);
        chk("reset rsp_vld", rsp_vld, '0);
        chk("reset rsp_data", rsp_data, '0);
        chk("reset unsol_vld", unsol_vld, 1'b0);
        chk("reset busy", busy, 1'b0);
        chk("reset send_en", send_en, 1'b0);
        chk("reset send_data", send_data, '0);
        rst = 1'b0;
        tick();

        foreach (vecs[k]) run_vec(vecs[k], k);

        // Round robin with all requests held, from pointer 0.
        reset_dut();
        tx_len       = 5;
        req_need_rsp = '0;
        req          = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            wait_ack(200, a, e, at, ns);
            if (k == 4) req = '0;
            chk($sformatf("rr grant %0d", k), a, oh(rr_exp[k]));
            chk($sformatf("rr send_en count %0d", k), ns, 1);
        end
        tick();
        tick();

        // No response: two resends, then err.
        req_need_rsp = 4'b0010;
        req          = 4'b0010;
        wait_ack(3 * (RTO + 20), a, e, at, ns);
        req = '0;
        chk("retry send_en count", ns, 3);
        chk("retry err", e, 4'b0010);
        chk("retry ack", a, '0);
        chk("retry spacing 1", se_cyc[1] - se_cyc[0], RTO + 5 + 5);
        chk("retry spacing 2", se_cyc[2] - se_cyc[1], RTO + 5 + 5);
        chk("retry err timing", at - se_cyc[2], RTO + 5 + 6);
        tick();
        tick();

        // Transmitter never starts.
        model_en     = 1'b0;
        req_need_rsp = '0;
        req          = 4'b0001;
        wait_ack(100, a, e, at, ns);
        req = '0;
        chk("start to err", e, 4'b0001);
        chk("start to ack", a, '0);
        chk("start to timing", at - se_cyc[0], STO + 3);
        model_en = 1'b1;
        tick();
        req = 4'b0100;
        wait_ack(100, a, e, at, ns);
        req = '0;
        chk("after start to ack", a, 4'b0100);
        tick();
        tick();

        // Unsolicited frame while idle.
        pulse_rx(128'h55AA);
        chk("unsol_vld", unsol_vld, 1'b1);
        chk("unsol busy", busy, 1'b0);
        chk("unsol rsp_data", rsp_data, 128'h55AA);
        chk("unsol rsp_vld", rsp_vld, '0);
        tick();

        // Reset during WAIT_RSP.
        req_need_rsp = 4'b1000;
        req          = 4'b1000;
        wait_lvl("rst txn rise", 1'b1);
        wait_lvl("rst txn fall", 1'b0);
        repeat (10) tick();
        chk("rst txn busy before", busy, 1'b1);
        a0  = tot_ack;
        e0  = tot_err;
        req = 4'b1010;
        rst = 1'b1;
        #1;
        chk("midrst busy", busy, 1'b0);
        chk("midrst send_data", send_data, '0);
        chk("midrst rsp_data", rsp_data, '0);
        chk("midrst ack/err", {ack, err}, '0);
        tick();
        tick();
        rst          = 1'b0;
        req_need_rsp = '0;
        wait_ack(100, a, e, at, ns);
        req = 4'b1000;
        chk("post rst grant", a, 4'b0010);
        wait_ack(100, a, e, at, ns);
        req = '0;
        chk("post rst grant 2", a, 4'b1000);
        tick();
        chk("rst no extra ack", tot_ack - a0, 2);
        chk("rst no err", tot_err - e0, 0);

        chk("pulse sanity", viol, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_cmd_sched.md
Name: uart_cmd_sched

Overview:
- Round-robin scheduler that shares the single 128-bit UART command link (framed send/receive path) between NUM_REQ internal requesters.
- Issues one command frame at a time and optionally waits for the matching response frame, with timeout and retry.
- Routes the response, or an error, back to the requester that was granted the link.
- Sits between control logic (RF config, status polling) and the UART command top.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_W, 128, command/response frame width
START_TO, 64, clk cycles allowed from send_en until send_vld rises
RSP_TO, 20000, clk cycles allowed from send_vld fall until response valid
MAX_RETRY, 2, resends after a response timeout (0 = none)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
req  in  NUM_REQ  level request per requester; hold until ack or err
req_data  in  NUM_REQ*DATA_W  frame of requester i at bits [i*DATA_W +: DATA_W]
req_need_rsp  in  NUM_REQ  requester i expects a response frame
ack  out  NUM_REQ  one-cycle pulse: transaction of requester i completed OK
err  out  NUM_REQ  one-cycle pulse: transaction of requester i failed (start or response timeout)
rsp_data  out  DATA_W  last accepted response frame, held until next one
rsp_vld  out  NUM_REQ  one-cycle pulse with rsp_data, to owner of the frame
unsol_vld  out  1  one-cycle pulse: response frame arrived with no transaction waiting
busy  out  1  high whenever state is not IDLE
send_en  out  1  one-cycle pulse to UART transmit framer
send_data  out  DATA_W  frame to transmit, stable from send_en until send_vld falls
send_vld  in  1  UART transmitter busy
rx_frame  in  DATA_W  decoded received frame
rx_vld  in  1  one-cycle pulse: rx_frame valid

Behaviour:
- Reset (async, rst=1): state IDLE; all outputs 0; rsp_data 0; rr pointer 0; retry and timeout counters 0. Reset mid-transaction aborts silently, with no ack and no err.
- States: IDLE, ARB, SEND, WAIT_START, WAIT_DONE, WAIT_RSP, FINISH.
- IDLE: stays while req == 0 or send_vld == 1. Otherwise goes to ARB.
- ARB (1 cycle): picks the first set req at or after the rr pointer, wrapping modulo NUM_REQ. Registers gnt_id, the frame into send_data, and need_rsp. Clears retry_cnt.
- SEND (1 cycle): send_en = 1. Then WAIT_START, clearing the timer. The first send_en therefore appears 2 cycles after req is seen in IDLE.
- WAIT_START:
  - send_vld = 1: go to WAIT_DONE.
  - Timer reaches START_TO: go to FINISH with err.
- WAIT_DONE: on send_vld = 0, go to WAIT_RSP if need_rsp (clear timer), else FINISH with ack.
- WAIT_RSP:
  - rx_vld: capture rsp_data, pulse rsp_vld[gnt_id] next cycle, go to FINISH with ack.
  - Timer reaches RSP_TO with retry_cnt < MAX_RETRY: increment retry_cnt, go to SEND (same send_data).
  - Timer reaches RSP_TO otherwise: go to FINISH with err.
  - rx_vld in the same cycle as the timeout: the response wins.
- FINISH (1 cycle):
  - Pulses ack or err for gnt_id.
  - Sets rr pointer to gnt_id+1, wrapping to 0 after NUM_REQ-1.
  - Returns to IDLE. A requester still holding req re-arbitrates only after the others are served (fairness).
- rx_vld in a state other than WAIT_DONE or WAIT_RSP: rsp_data updated, unsol_vld pulsed, state unaffected.
  - rx_vld during WAIT_DONE is accepted as the response if need_rsp: FINISH directly after send_vld falls, with no WAIT_RSP wait.
- Dropping req after ARB does not cancel the transaction; ack or err still pulses.
- req_data changes after ARB are ignored.
- Timers: width clog2(max(START_TO,RSP_TO))+1, saturating; no wrap.
- At most one bit of ack/err/rsp_vld set per cycle; ack and err are never set together.

Decomposition:
- Shared package uart_cmd_pkg: state enum, DATA_W constant, function clog2.
- One natural sub-module: rr_arbiter (NUM_REQ request vector plus pointer in, one-hot grant and index out; purely combinational). It is reused by other link schedulers.
- Timer and FSM live in uart_cmd_sched.

Test Plan:
1. req=4'b0001, need_rsp=0, data 0x1234..; model raises send_vld 3 cycles after send_en for 100 cycles -> send_en 2 cycles after req; send_data = frame; ack[0] 2 cycles after send_vld falls.
2. req=4'b1111 held, rr=0, no responses needed -> grant order 0,1,2,3,0; exactly one send_en per transaction; never two outstanding.
3. req[2], need_rsp=1; rx_vld with 0xC0FFEE 500 cycles after send_vld falls -> rsp_vld[2] with rsp_data=0xC0FFEE, then ack[2]; err stays 0.
4. req[1], need_rsp=1, no response -> 3 send_en pulses (MAX_RETRY=2) spaced by RSP_TO plus transmit time, then err[1]; ack[1] never asserted.
5. send_vld never rises -> err at START_TO+3 cycles after send_en; a later req is served normally. Separately: rx_vld while IDLE -> unsol_vld=1, busy=0.
6. rst asserted during WAIT_RSP -> outputs 0 in the same cycle, state IDLE; no ack/err; after release, pending req[3] is re-granted from rr=0.
